// File: rtl/uart_tx_arbiter.sv
// Four-way round-robin arbiter that feeds one shared UART transmitter, one byte per grant,
// with a busy-rise timeout and an inter-frame idle gap.
module uart_tx_arbiter #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned UART_BPS = 115200,
    parameter int unsigned GAP_BITS = 1,
    parameter int unsigned BUSY_TMO = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic [1:0]  grant_id,
    output logic        arb_busy,
    output logic        tx_err
);

    localparam int unsigned BIT_CYC = CLK_FREQ / UART_BPS;
    localparam int unsigned GAP_RAW = GAP_BITS * BIT_CYC;
    localparam int unsigned GAP_CYC = (GAP_RAW == 0) ? 1 : GAP_RAW;
    localparam int unsigned TMO_CYC = (BUSY_TMO == 0) ? 1 : BUSY_TMO;
    localparam int unsigned GAP_W   = $clog2(GAP_CYC + 1);
    localparam int unsigned TMO_W   = $clog2(TMO_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_HI,
        WAIT_LO,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         req_ready_q, req_ready_d;
    logic               tx_en_q, tx_en_d;
    logic               tx_err_q, tx_err_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [1:0]         grant_id_q, grant_id_d;
    logic [1:0]         last_grant_q, last_grant_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic [1:0]         pick;
    logic               pick_ok;
    logic [1:0]         cand;

    // Search starts one past the last grant so a continuously valid requester cannot starve others.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last_grant_q + 2'(k);
            if (!pick_ok && req_valid[cand]) begin
                pick    = cand;
                pick_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            req_ready_q  <= '0;
            tx_en_q      <= 1'b0;
            tx_err_q     <= 1'b0;
            tx_data_q    <= '0;
            grant_id_q   <= '0;
            last_grant_q <= 2'd3;
            tmo_cnt_q    <= '0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            tx_en_q      <= tx_en_d;
            tx_err_q     <= tx_err_d;
            tx_data_q    <= tx_data_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            tmo_cnt_q    <= tmo_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = '0;
        tx_en_d      = 1'b0;
        tx_err_d     = 1'b0;
        tx_data_d    = tx_data_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        tmo_cnt_d    = tmo_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (!tx_busy && pick_ok) begin
                    req_ready_d[pick] = 1'b1;
                    tx_data_d         = req_data[{pick, 3'b000} +: 8];
                    grant_id_d        = pick;
                    last_grant_d      = pick;
                    state_d           = SEND;
                end
            end
            SEND: begin
                tx_en_d   = 1'b1;
                tmo_cnt_d = '0;
                state_d   = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
                    tx_err_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = req_ready_q;
    assign tx_en     = tx_en_q;
    assign tx_err    = tx_err_q;
    assign tx_data   = tx_data_q;
    assign grant_id  = grant_id_q;
    assign arb_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a simple transmitter model plus hand-computed
// expectations for grant order, latency, gap length, timeout and reset behaviour.
module tb_uart_tx_arbiter;

    logic        sys_clk;
    logic        sys_rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        arb_busy;
    logic        tx_err;

    logic        model_busy;
    logic        force_busy;
    logic        model_en;
    int unsigned frame_cyc;

    int unsigned cyc;
    int unsigned rdy_cnt;
    int unsigned en_cnt;
    int unsigned idle_edge;
    int unsigned fall_edge;
    int unsigned checks;
    int unsigned failures;

    assign tx_busy = model_busy | force_busy;

    uart_tx_arbiter #(
        .CLK_FREQ(50000000),
        .UART_BPS(115200),
        .GAP_BITS(1),
        .BUSY_TMO(8)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .grant_id (grant_id),
        .arb_busy (arb_busy),
        .tx_err   (tx_err)
    );

    initial begin
        sys_clk = 1'b0;
        forever #10 sys_clk = ~sys_clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge sys_clk);
            cyc = cyc + 1;
        end
    end

    // Transmitter: busy rises two edges after tx_en is seen, stays up for frame_cyc edges.
    initial begin
        model_busy = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (model_en && tx_en) begin
                repeat (2) @(posedge sys_clk);
                #1 model_busy = 1'b1;
                repeat (frame_cyc) @(posedge sys_clk);
                #1 model_busy = 1'b0;
            end
        end
    end

    initial begin
        logic prev_arb;
        logic prev_busy;
        rdy_cnt   = 0;
        en_cnt    = 0;
        idle_edge = 0;
        fall_edge = 0;
        prev_arb  = 1'b0;
        prev_busy = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (|req_ready) rdy_cnt = rdy_cnt + 1;
            if (tx_en) en_cnt = en_cnt + 1;
            if (prev_arb && !arb_busy) idle_edge = cyc;
            if (prev_busy && !tx_busy) fall_edge = cyc + 1;
            prev_arb  = arb_busy;
            prev_busy = tx_busy;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int unsigned limit);
        int unsigned n;
        n = 0;
        @(negedge sys_clk);
        while (arb_busy && n < limit) begin
            @(negedge sys_clk);
            n = n + 1;
        end
        check_val(tag, 32'(arb_busy), 32'd0);
    endtask

    task automatic wait_ready(input string tag, input int unsigned limit);
        int unsigned n;
        n = 0;
        @(negedge sys_clk);
        while (req_ready == 4'b0000 && n < limit) begin
            @(negedge sys_clk);
            n = n + 1;
        end
        check_val(tag, 32'(|req_ready), 32'd1);
    endtask

    initial begin
        int unsigned base_r;
        int unsigned base_e;
        int unsigned t_en;
        int unsigned n;
        checks     = 0;
        failures   = 0;
        sys_rst    = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        force_busy = 1'b0;
        model_en   = 1'b1;
        frame_cyc  = 4340;

        repeat (3) @(negedge sys_clk);
        check_val("rst_ready",   32'(req_ready), 32'd0);
        check_val("rst_tx_en",   32'(tx_en),     32'd0);
        check_val("rst_tx_data", 32'(tx_data),   32'd0);
        check_val("rst_grant",   32'(grant_id),  32'd0);
        check_val("rst_arb",     32'(arb_busy),  32'd0);
        check_val("rst_err",     32'(tx_err),    32'd0);
        sys_rst = 1'b0;

        // Single request from requester 2.
        base_r    = rdy_cnt;
        base_e    = en_cnt;
        req_valid = 4'b0100;
        req_data  = 32'h0055_0000;
        wait_ready("single_wait", 5);
        check_val("single_ready", 32'(req_ready), 32'h4);
        check_val("single_data",  32'(tx_data),   32'h55);
        check_val("single_gid",   32'(grant_id),  32'd2);
        req_valid = '0;
        @(negedge sys_clk);
        check_val("single_tx_en", 32'(tx_en),     32'd1);
        check_val("single_rdy_0", 32'(req_ready), 32'd0);
        wait_idle("single_idle", 6000);
        check_val("single_rdy_cnt", rdy_cnt - base_r, 32'd1);
        check_val("single_en_cnt",  en_cnt - base_e,  32'd1);

        // Round robin from a fresh reset: expect A0,A1,A2,A3 with exact gap and restart timing.
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst   = 1'b0;
        frame_cyc = 100;
        base_r    = rdy_cnt;
        base_e    = en_cnt;
        req_valid = 4'hF;
        req_data  = 32'hA3A2_A1A0;
        n = 0;
        for (int i = 0; i < 6000 && n < 4; i++) begin
            @(negedge sys_clk);
            if (|req_ready) req_valid = req_valid & ~req_ready;
            if (tx_en) begin
                check_val("rr_data", 32'(tx_data), 32'hA0 + n);
                check_val("rr_gid",  32'(grant_id), n);
                if (n > 0) begin
                    check_val("rr_en_after_idle", cyc - idle_edge, 32'd2);
                    check_val("gap_len", idle_edge - fall_edge, 32'd434);
                end
                n = n + 1;
            end
        end
        check_val("rr_frames", n, 32'd4);
        wait_idle("rr_idle", 2000);
        check_val("rr_rdy_cnt", rdy_cnt - base_r, 32'd4);
        check_val("rr_en_cnt",  en_cnt - base_e,  32'd4);

        // Transmitter never responds: timeout 8 cycles after WAIT_HI entry.
        model_en  = 1'b0;
        req_valid = 4'b0010;
        req_data  = 32'h0000_7700;
        wait_ready("tmo_wait", 5);
        req_valid = '0;
        @(negedge sys_clk);
        t_en = cyc;
        check_val("tmo_tx_en", 32'(tx_en), 32'd1);
        n = 0;
        while (!tx_err && n < 20) begin
            @(negedge sys_clk);
            n = n + 1;
        end
        check_val("tmo_delay", cyc - t_en, 32'd8);
        check_val("tmo_idle", 32'(arb_busy), 32'd0);
        req_valid = 4'b1000;
        req_data  = 32'h9900_0000;
        wait_ready("tmo_next_wait", 5);
        check_val("tmo_next_ready", 32'(req_ready), 32'h8);
        check_val("tmo_next_data",  32'(tx_data),   32'h99);
        req_valid = '0;
        wait_idle("tmo_next_idle", 40);

        // Reset during WAIT_LO after granting requester 0.
        model_en  = 1'b1;
        frame_cyc = 200;
        req_valid = 4'b0001;
        req_data  = 32'h0000_0011;
        wait_ready("rstmid_wait", 5);
        req_valid = '0;
        n = 0;
        while (!tx_busy && n < 20) begin
            @(negedge sys_clk);
            n = n + 1;
        end
        repeat (5) @(negedge sys_clk);
        check_val("rstmid_pre_arb", 32'(arb_busy), 32'd1);
        sys_rst = 1'b1;
        #1;
        check_val("rstmid_arb",   32'(arb_busy), 32'd0);
        check_val("rstmid_data",  32'(tx_data),  32'd0);
        check_val("rstmid_gid",   32'(grant_id), 32'd0);
        req_valid = 4'b0011;
        req_data  = 32'h0000_2211;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        base_r  = rdy_cnt;
        base_e  = en_cnt;
        n = 0;
        while (tx_busy && n < 400) begin
            @(negedge sys_clk);
            n = n + 1;
        end
        check_val("rstmid_hold_rdy", rdy_cnt - base_r, 32'd0);
        check_val("rstmid_hold_en",  en_cnt - base_e,  32'd0);
        @(negedge sys_clk);
        check_val("rstmid_first", 32'(req_ready), 32'h1);
        req_valid = '0;
        wait_idle("rstmid_idle", 2000);

        // Busy held externally blocks the grant until it drops.
        model_en   = 1'b0;
        force_busy = 1'b1;
        req_valid  = 4'b0001;
        req_data   = 32'h0000_0042;
        base_r     = rdy_cnt;
        repeat (20) @(negedge sys_clk);
        check_val("held_no_rdy", rdy_cnt - base_r, 32'd0);
        force_busy = 1'b0;
        @(negedge sys_clk);
        check_val("held_ready", 32'(req_ready), 32'h1);
        check_val("held_data",  32'(tx_data),   32'h42);
        req_valid = '0;
        wait_idle("held_idle", 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
